// File: rtl/freq_meter_core.sv
// Gated frequency meter: counts synchronized rising edges of sigin over a fixed
// window (optionally prescaled) and latches a 4-digit BCD result for display.
module freq_meter_core #(
    parameter int GATE_CYCLES = 100000000,
    parameter int DIV_HIGH    = 10
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        sigin,
    input  logic        modecontrol,
    output logic [15:0] bcd,
    output logic        overflow,
    output logic        highfreq,
    output logic        valid
);

    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int PW = (DIV_HIGH > 1) ? $clog2(DIV_HIGH) : 1;

    typedef enum logic [1:0] {CLEAR, COUNT, LATCH} state_t;

    state_t          state, next_state;
    logic            sync_1, sync_2, sync_3;
    logic            edge_det;
    logic [PW-1:0]   pre_cnt;
    logic [GW-1:0]   gate_cnt;
    logic [15:0]     cnt_bcd;
    logic            ovf;
    logic            range_q;
    logic            gate_done;
    logic            range_change;
    logic            pre_wrap;
    logic            count_en;

    // Ripple a +1 through four mod-10 digits in a single cycle.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        logic [3:0]  d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= sigin;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign edge_det     = sync_2 & ~sync_3;
    assign gate_done    = (gate_cnt == GW'(GATE_CYCLES - 1));
    assign range_change = (modecontrol != range_q);
    assign pre_wrap     = (pre_cnt == PW'(DIV_HIGH - 1));
    assign count_en     = (state == COUNT) && edge_det && (!range_q || pre_wrap);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR: next_state = COUNT;
            COUNT: begin
                if (range_change) begin
                    next_state = CLEAR;
                end else if (gate_done) begin
                    next_state = LATCH;
                end
            end
            LATCH:   next_state = CLEAR;
            default: next_state = CLEAR;
        endcase
    end

    // Window bookkeeping: gate counter, prescaler and latched range.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            pre_cnt  <= '0;
            range_q  <= 1'b0;
        end else if (state == CLEAR) begin
            gate_cnt <= '0;
            pre_cnt  <= '0;
            range_q  <= modecontrol;
        end else if (state == COUNT) begin
            gate_cnt <= gate_cnt + GW'(1);
            if (edge_det && range_q) begin
                pre_cnt <= pre_wrap ? '0 : pre_cnt + PW'(1);
            end
        end
    end

    // Saturating BCD event counter.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_bcd <= '0;
            ovf     <= 1'b0;
        end else if (state == CLEAR) begin
            cnt_bcd <= '0;
            ovf     <= 1'b0;
        end else if (count_en) begin
            if (cnt_bcd == 16'h9999) begin
                ovf <= 1'b1;
            end else begin
                cnt_bcd <= bcd_inc(cnt_bcd);
            end
        end
    end

    // Display-facing result registers; only LATCH touches them.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            bcd      <= '0;
            overflow <= 1'b0;
            highfreq <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= (state == LATCH);
            if (state == LATCH) begin
                bcd      <= cnt_bcd;
                overflow <= ovf;
                highfreq <= range_q;
            end
        end
    end

endmodule

// File: doc/freq_meter_core.md
Name: freq_meter_core

Overview:
- Measurement stage between the test-signal generator (`testmode`-selected frequencies) and the 7-segment scanner that drives `cathodes`/`AN`.
- Counts rising edges of an asynchronous input over a fixed gate window.
- Supports a ÷10 high-frequency range.
- Presents a latched 4-digit BCD result, an overflow flag and a range indicator to the display stage.

Parameters:
- GATE_CYCLES, 100000000, `sysclk` cycles per gate window (1 s at 100 MHz); benches use 1000.
- DIV_HIGH, 10, input prescale ratio in high range.

Ports:
- sysclk  input  1  system clock, 100 MHz nominal.
- rst_n  input  1  asynchronous active-low reset.
- sigin  input  1  asynchronous signal under measurement.
- modecontrol  input  1  range select: 0 counts every edge; 1 counts every DIV_HIGH-th edge.
- bcd  output  16  latched result, 4 BCD digits, [15:12] most significant.
- overflow  output  1  latched: count exceeded 9999 in last window.
- highfreq  output  1  range in effect for the currently displayed result.
- valid  output  1  one-cycle pulse when bcd/overflow/highfreq update.

Behaviour:
- Reset (`rst_n`=0, async): bcd=0, overflow=0, highfreq=0, valid=0. Synchronizers, prescaler, BCD counter and gate counter are all cleared. FSM enters CLEAR. Reset mid-window discards the partial count.
- Input path:
  - 2-flop synchronizer, then a rising-edge detector. Edge-to-count latency is 3 cycles.
  - An edge requires sigin high ≥1 cycle and low ≥1 cycle. Faster inputs are out of spec.
- Prescaler:
  - Mod-DIV_HIGH counter (0..DIV_HIGH-1) advanced by detected edges.
  - Emits a count enable when it wraps from DIV_HIGH-1 to 0.
  - Used only when the latched range is 1. In range 0, every edge is a count enable.
- BCD counter:
  - 4 cascaded mod-10 digits; the carry ripples in the same cycle.
  - Incrementing from 9999 sets an internal ovf bit and holds the digits at 9999 (saturate).
- FSM states:
  - CLEAR (1 cycle): zero BCD counter, ovf, prescaler and gate counter. Sample modecontrol into range_q. Go to COUNT.
  - COUNT: gate counter increments each cycle. Count enables are accepted. After exactly GATE_CYCLES cycles in COUNT, go to LATCH.
  - LATCH (1 cycle): bcd<=counter, overflow<=ovf, highfreq<=range_q, valid=1. Go to CLEAR.
  - Edges detected during CLEAR or LATCH are dropped (2-cycle dead time per window).
- Range change: if modecontrol differs from range_q during COUNT, abort to CLEAR without latching. Outputs keep their previous values and valid stays 0.
- Window period is GATE_CYCLES+2 cycles. Outputs are stable between valid pulses.
- The gate counter is wide enough for GATE_CYCLES; use $clog2 sizing.

Test Plan (GATE_CYCLES=1000):
- Reset asserted mid-COUNT with sigin toggling → all outputs 0 immediately (asynchronously). First valid occurs 1002 cycles after rst_n release.
- sigin period 10 cycles, modecontrol=0 → bcd=16'h0100 (±1 LSB for phase), overflow=0, highfreq=0, valid exactly every 1002 cycles.
- sigin period 2 cycles, modecontrol=0 → bcd=16'h0500 ±1.
- sigin period 2 cycles, modecontrol=1 → bcd=16'h0050 ±1, highfreq=1.
- Same input with GATE_CYCLES=30000, modecontrol=0 → 15000 edges, so bcd=16'h9999 and overflow=1. Next window at period 10 → overflow=0, bcd=16'h3000 ±1.
- Toggle modecontrol mid-window → no valid for that window, bcd unchanged. Next valid arrives 1002 cycles after the toggle, with highfreq equal to the new mode.
